mips_mc_core: RTL and testbench
===============================

# mips_mc_core

Parametrised multi-cycle successor to the 8-bit single-cycle MIPS demo datapath. It owns its program counter and sequences fetch, decode, execute, memory and writeback through an FSM. Instruction and data memories are external, behind req/ack handshakes, so wait-state memories can be attached. Data width and PC width are generic, and it adds conditional branch, load/store, halt and illegal-opcode detection.

## Interface
- DATA_W, 8: register, ALU and data-memory word width (≥4)
- PC_W, 8: program counter and instruction/data address width (≤8 addresses reachable by imm)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  when low, core holds in FETCH without issuing a request
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  instruction valid this cycle
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  PC_W  R[rs] truncated/zero-extended to PC_W
- dmem_wdata  out  DATA_W  R[rd]
- dmem_ack  in  1  access complete; load data valid this cycle
- dmem_rdata  in  DATA_W  load data
- pc  out  PC_W  current program counter
- acc  out  DATA_W  last ALU result
- flag_z, flag_c  out  1  zero / carry of last ALU op
- halted  out  1  core stopped by HALT
- illegal  out  1  sticky: undefined opcode executed
- dbg_sel  in  2  register select for debug read
- dbg_data  out  DATA_W  R[dbg_sel], combinational

## Operation
- Four registers R0–R3, DATA_W each; R0 is writable (not hardwired).
- Instruction: op[15:12], rd[11:10], rs[9:8], imm[7:0]; imm zero-extended/truncated to DATA_W or PC_W.
- Opcodes: 0 NOP; 1 ADD rd=rd+rs; 2 SUB rd=rd−rs; 3 AND; 4 OR; 5 XOR; 6 LI rd=imm; 7 LW rd=M[R[rs]]; 8 SW M[R[rs]]=R[rd]; 9 BEQZ if R[rd]==0 pc=imm; A JMP pc=imm; F HALT; B–E undefined → executed as NOP, illegal set.
- ALU ops (1–5) update acc, flag_z (result==0), flag_c (ADD: carry-out bit DATA_W; SUB: borrow, i.e. R[rd]<R[rs] unsigned; logic: 0). LI, LW, SW, branches leave acc/flags unchanged.
- Arithmetic modulo 2^DATA_W; pc increments modulo 2^PC_W (0xFF→0x00 at PC_W=8).
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: if run, imem_req=1; on imem_ack latch instruction, pc←pc+1, go DECODE.
  - DECODE: read operands; op 7/8 → MEM; op F → HALT; else → EXEC.
  - EXEC: ALU/LI write rd, branch/jump update pc; → FETCH.
  - MEM: dmem_req=1, dmem_we=(op==8); on dmem_ack: load → WB (rdata captured), store → FETCH.
  - WB: rd←captured load data; → FETCH.
  - HALT: halted=1, no requests; exit only by reset.
- Branch targets are absolute; pc already incremented is overwritten.

## Timing
- Reset values: pc=0, R0–R3=0, acc=0, flags=0, halted=0, illegal=0, imem_req=dmem_req=dmem_we=0, state=FETCH.
- Assertion of reset clears state immediately, including mid-handshake (req drops asynchronously).
- Requests rise on the cycle the FSM enters FETCH/MEM and stay high until the cycle ack is sampled high; address/wdata stable throughout. Ack while req low is ignored.
- Zero-wait latency: ALU/LI/branch/jump/NOP 3 cycles; SW 3; LW 4; each wait cycle on ack adds one.
- imem_ack in the first FETCH cycle: instruction consumed that edge; next request no earlier than two cycles later.
- run deasserted in FETCH before ack: imem_req drops, state held; run deasserted after req accepted is ignored until next FETCH.
- dbg_data reflects a register write from the following cycle.

## Test plan
- Reset then LI R1,0x05; LI R2,0x03; ADD R1,R2 with zero-wait imem → R1=0x08, acc=0x08, flag_z=0, pc=3 after 9 cycles.
- LI R1,0xFF; LI R2,0x01; ADD R1,R2 → R1=0x00, flag_z=1, flag_c=1; SUB R2,R1 afterwards → 0x01, flag_c=0.
- SW then LW at address 0x10 with dmem_ack delayed 2 cycles → req held 3 cycles, dmem_we correct, loaded register equals stored value, LW takes 6 cycles.
- BEQZ R0,0x20 with R0=0 → pc=0x20; with R0=1 → pc=pc+1; JMP 0xFF then NOP → pc wraps to 0x00.
- Opcode 0xC then HALT → illegal=1, halted=1, no further imem_req; reset asserted mid-fetch with ack pending → imem_req low immediately, pc=0.

Source files
------------

// File: rtl/mips_mc_core_if.sv
// Memory-side bus of mips_mc_core: instruction fetch and data access, each a req/ack pair.
`timescale 1ns/1ps

// Handshake: the core raises req with its address (and store data) stable and holds it
// until the cycle in which it samples ack high; ack while req is low has no effect.
interface mips_mc_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [PC_W-1:0]   dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mips_mc_core.sv
// Multi-cycle 4-register MIPS-like core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with
// external wait-state instruction and data memories.
`timescale 1ns/1ps

module mips_mc_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  mips_mc_core_if.master    bus,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  output logic              illegal,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [15:0]       ir;
  logic [DATA_W-1:0] rf [4];
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] ld_data;
  logic [3:0]        op;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   imm_p;
  logic              fetch_fire;
  logic              mem_fire;
  logic              is_mem_op;
  logic              is_store;
  logic [DATA_W:0]   ext_add;
  logic [DATA_W:0]   ext_sub;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_op;

  assign op       = ir[15:12];
  assign rd       = ir[11:10];
  assign rs       = ir[9:8];
  assign imm_d    = DATA_W'(ir[7:0]);
  assign imm_p    = PC_W'(ir[7:0]);
  assign is_store = (op == 4'h8);
  assign is_mem_op = (op == 4'h7) || is_store;

  assign fetch_fire = bus.imem_req && bus.imem_ack;
  assign mem_fire   = bus.dmem_req && bus.dmem_ack;

  assign dbg_data  = rf[dbg_sel];
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:  if (fetch_fire) state_nx = S_DECODE;
      S_DECODE: begin
        if (is_mem_op)         state_nx = S_MEM;
        else if (op == 4'hF)   state_nx = S_HALT;
        else                   state_nx = S_EXEC;
      end
      S_EXEC:   state_nx = S_FETCH;
      S_MEM:    if (mem_fire) state_nx = is_store ? S_FETCH : S_WB;
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Outputs: reset gates the requests so they drop the moment reset rises.
  always_comb begin
    bus.imem_req   = (state == S_FETCH) && run && !reset;
    bus.imem_addr  = pc;
    bus.dmem_req   = (state == S_MEM) && !reset;
    bus.dmem_we    = (state == S_MEM) && is_store && !reset;
    bus.dmem_addr  = PC_W'(opb);
    bus.dmem_wdata = opa;
    halted         = (state == S_HALT);
  end

  // ALU on the operands latched in DECODE (opa = R[rd], opb = R[rs]).
  always_comb begin
    ext_add = {1'b0, opa} + {1'b0, opb};
    ext_sub = {1'b0, opa} - {1'b0, opb};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_op  = 1'b1;
    case (op)
      4'h1: begin alu_res = ext_add[DATA_W-1:0]; alu_c = ext_add[DATA_W]; end
      4'h2: begin alu_res = ext_sub[DATA_W-1:0]; alu_c = ext_sub[DATA_W]; end
      4'h3: alu_res = opa & opb;
      4'h4: alu_res = opa | opb;
      4'h5: alu_res = opa ^ opb;
      default: alu_op = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      opa     <= '0;
      opb     <= '0;
      ld_data <= '0;
      acc     <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (fetch_fire) begin
            ir <= bus.imem_rdata;
            pc <= pc + PC_W'(1);
          end
        end
        S_DECODE: begin
          opa <= rf[rd];
          opb <= rf[rs];
        end
        S_EXEC: begin
          if (alu_op) begin
            rf[rd] <= alu_res;
            acc    <= alu_res;
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
          end
          case (op)
            4'h6: rf[rd] <= imm_d;
            // Branch targets are absolute and override the already-incremented pc.
            4'h9: if (opa == '0) pc <= imm_p;
            4'hA: pc <= imm_p;
            4'hB, 4'hC, 4'hD, 4'hE: illegal <= 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_fire && !is_store) ld_data <= bus.dmem_rdata;
        end
        S_WB:   rf[rd] <= ld_data;
        S_HALT: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Bench for mips_mc_core: wait-state memory responders, data-access scoreboard and
// cycle-exact architectural checks over small programs.
`timescale 1ns/1ps

module tb_mips_mc_core;
  localparam int DATA_W = 8;
  localparam int PC_W   = 8;
  localparam int SB_W   = 1 + PC_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              run = 1'b1;
  logic [1:0]        dbg_sel = 2'd0;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] dbg_data;
  logic              flag_z, flag_c, halted, illegal;
  logic [2:0]        dbg_state;

  logic [15:0]       imem [256];
  logic [DATA_W-1:0] dmem [256];
  logic [SB_W-1:0]   exp_q [$];
  int imem_wait = 0;
  int dmem_wait = 0;
  int n_checks = 0;
  int n_fail = 0;
  int i_high = 0;
  int i_total = 0;
  int d_high = 0;
  int i_snap;
  logic [PC_W-1:0] d_addr0;
  logic [SB_W-1:0] e;

  mips_mc_core_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  mips_mc_core #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .bus       (bus.master),
    .pc        (pc),
    .acc       (acc),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .halted    (halted),
    .illegal   (illegal),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // Clock
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    dbg_sel = idx;
    #1;
    check(tag, 32'(dbg_data), exp);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'hF000;
      dmem[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Instruction memory: ack after imem_wait extra cycles of held request.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      if (bus.imem_req) begin
        i_high++;
        i_total++;
        if (i_high == imem_wait + 1) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = imem[bus.imem_addr];
        end
      end else begin
        i_high = 0;
      end
    end
  end

  // Data memory with scoreboard of expected accesses {we, addr, data}.
  initial begin
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      if (bus.dmem_req) begin
        d_high++;
        if (d_high == 1) d_addr0 = bus.dmem_addr;
        if (d_high == dmem_wait + 1) begin
          bus.dmem_ack = 1'b1;
          check("dmem_addr_stable", 32'(bus.dmem_addr), 32'(d_addr0));
          if (exp_q.size() == 0) begin
            check("dmem_unexpected", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            if (bus.dmem_we)
              check("store", 32'({bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}), 32'(e));
            else
              check("load_req", 32'({bus.dmem_we, bus.dmem_addr}), 32'(e[SB_W-1:DATA_W]));
          end
          if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
          else             bus.dmem_rdata = dmem[bus.dmem_addr];
        end
      end else begin
        if (d_high != 0) check("dmem_req_hold", 32'(d_high), 32'(dmem_wait + 1));
        d_high = 0;
      end
    end
  end

  initial begin
    clear_prog();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", 32'(pc), 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_flags", 32'({flag_z, flag_c}), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_reqs", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we}), 0);
    check("rst_state", 32'(dbg_state), 0);
    for (int r = 0; r < 4; r++) check_reg("rst_reg", 2'(r), 0);

    // LI R1,5; LI R2,3; ADD R1,R2
    clear_prog();
    imem[0] = 16'h6405; imem[1] = 16'h6803; imem[2] = 16'h1600;
    do_reset();
    step(9);
    check("add_pc", 32'(pc), 3);
    check("add_acc", 32'(acc), 8);
    check("add_flags", 32'({flag_z, flag_c}), 0);
    check_reg("add_r1", 2'd1, 8);
    check_reg("add_r2", 2'd2, 3);
    // Hold with run low, then release into HALT
    run = 1'b0;
    step(4);
    check("run_hold_pc", 32'(pc), 3);
    check("run_hold_req", 32'(bus.imem_req), 0);
    run = 1'b1;
    step(2);
    check("run_halt", 32'(halted), 1);
    check("run_halt_pc", 32'(pc), 4);

    // Carry/zero then SUB
    clear_prog();
    imem[0] = 16'h64FF; imem[1] = 16'h6801; imem[2] = 16'h1600; imem[3] = 16'h2900;
    do_reset();
    step(9);
    check_reg("addc_r1", 2'd1, 0);
    check("addc_flags", 32'({flag_z, flag_c}), 32'(2'b11));
    check("addc_acc", 32'(acc), 0);
    step(3);
    check_reg("sub_r2", 2'd2, 1);
    check("sub_flags", 32'({flag_z, flag_c}), 0);
    check("sub_acc", 32'(acc), 1);

    // SW then LW at 0x10 with two wait cycles on dmem_ack
    clear_prog();
    imem[0] = 16'h6410; imem[1] = 16'h685A; imem[2] = 16'h8900; imem[3] = 16'h7D00;
    dmem_wait = 2;
    exp_q.push_back({1'b1, 8'h10, 8'h5A});
    exp_q.push_back({1'b0, 8'h10, 8'h5A});
    do_reset();
    step(16);
    check_reg("lw_not_yet", 2'd3, 0);
    step(1);
    check_reg("lw_r3", 2'd3, 32'h5A);
    check("lw_pc", 32'(pc), 4);
    check("sw_mem", 32'(dmem[8'h10]), 32'h5A);
    check("sb_empty", 32'(exp_q.size()), 0);
    dmem_wait = 0;

    // Branches and pc wrap
    clear_prog();
    imem[8'h00] = 16'h9020; imem[8'h20] = 16'h6001; imem[8'h21] = 16'h9040;
    imem[8'h22] = 16'hA0FF; imem[8'hFF] = 16'h0000;
    do_reset();
    step(3);
    check("beqz_taken", 32'(pc), 32'h20);
    step(6);
    check("beqz_not_taken", 32'(pc), 32'h22);
    check_reg("li_r0", 2'd0, 1);
    step(3);
    check("jmp", 32'(pc), 32'hFF);
    step(3);
    check("pc_wrap", 32'(pc), 0);
    step(3);
    check("beqz_r0_one", 32'(pc), 1);
    check("branch_acc", 32'(acc), 0);

    // Illegal opcode then HALT
    clear_prog();
    imem[0] = 16'hC000; imem[1] = 16'hF000;
    do_reset();
    step(3);
    check("illegal_set", 32'(illegal), 1);
    check("not_halted_yet", 32'(halted), 0);
    step(2);
    check("halted", 32'(halted), 1);
    i_snap = i_total;
    step(10);
    check("halt_no_req", 32'(i_total - i_snap), 0);
    check("halt_pc", 32'(pc), 2);
    check("illegal_sticky", 32'(illegal), 1);

    // Reset mid-fetch with ack pending
    clear_prog();
    imem[0] = 16'h0000; imem[1] = 16'h0000;
    do_reset();
    step(6);
    check("nop_pc", 32'(pc), 2);
    imem_wait = 3;
    step(1);
    check("fetch_pending", 32'(bus.imem_req), 1);
    #2 reset = 1'b1;
    #1;
    check("midfetch_req", 32'(bus.imem_req), 0);
    check("midfetch_pc", 32'(pc), 0);
    check("midfetch_state", 32'(dbg_state), 0);
    step(2);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
